store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- In-order FIFO of completed stores, directly downstream of the load/store execution unit.
- Accepts store results (address, data, size, tag) when the unit reports a finished store, holds them until the ROB commits them, then drains committed stores to the data cache one at a time.
- Provides store-to-load forwarding lookup for the load path.
- Discards uncommitted entries on pipeline flush.

Parameters:
DEPTH, 4, number of entries; power of two, >=2
TAG_WIDTH, 6, width of ROB tag carried per store

Ports:
i_clock  input  1  clock, all state on rising edge
i_reset  input  1  synchronous, active-high reset
i_valid  input  1  store result present this cycle (load/store unit ready with a store)
i_address  input  32  store address (base + immediate)
i_data  input  32  store data, right-aligned
i_store_type  input  2  0=word, 1=half, 2=byte, 3=reserved (treated as word)
i_tag  input  TAG_WIDTH  ROB tag of the store
o_full  output  1  no free entry; i_valid ignored while high
o_empty  output  1  no valid entries
o_count  output  $clog2(DEPTH)+1  valid entry count
i_commit  input  1  ROB retires a store this cycle
i_commit_tag  input  TAG_WIDTH  tag of retiring store
o_commit_error  output  1  registered pulse: commit tag did not match oldest uncommitted entry
i_flush  input  1  discard all uncommitted entries
o_mem_write  output  1  write request to data cache
o_mem_address  output  32  head entry address
o_mem_data  output  32  head entry data
o_mem_store_type  output  2  head entry size
i_mem_ready  input  1  cache accepted the write
i_fwd_address  input  32  load address to check
o_fwd_hit  output  1  youngest matching entry is a word store to same word address
o_fwd_data  output  32  data of that entry
o_fwd_stall  output  1  youngest matching entry (same address[31:2]) is a sub-word store; load must wait

Behaviour:
- Storage: circular array with head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count register, and per-entry valid and committed bits.
- Reset: pointers, count, all valid/committed bits, o_mem_write and o_commit_error = 0. o_empty=1, o_full=0, o_fwd_* = 0.
- o_full = (count==DEPTH) and o_empty = (count==0), both from registered count.
- Enqueue: when i_valid && !o_full && !i_flush, write the entry at tail, set valid=1 and committed=0, tail+1. Entry visible to forwarding next cycle.
- Commit: pointer cpos tracks the oldest uncommitted entry; committed entries always form a prefix from head.
  - If i_commit, entry at cpos is valid/uncommitted and its tag == i_commit_tag: set committed and advance cpos.
  - Otherwise no state change, and o_commit_error pulses one cycle later.
  - Commit of an entry enqueued in the same cycle is not allowed: it raises the error.
- Drain FSM:
  - IDLE: if head entry is valid and committed, go to WRITE next cycle with o_mem_write=1.
  - WRITE: o_mem_* hold head contents stable until i_mem_ready. On the i_mem_ready cycle: clear head valid/committed, head+1, count-1, drop o_mem_write next cycle, return to IDLE.
  - Min 2 cycles per store; back-to-back stores have one idle cycle between writes.
- Flush: on i_flush, clear all uncommitted entries and set tail = cpos and count = committed count.
  - An in-progress WRITE is unaffected, because the head is committed.
  - A same-cycle commit is applied before the flush (the committed entry survives).
  - A same-cycle enqueue is dropped.
- Simultaneous enqueue and pop: both apply and count is unchanged. When full, enqueue is refused even if a pop occurs that cycle.
- Forwarding (combinational): scan valid entries from youngest to oldest, comparing address[31:2].
  - First match with a word store at address[1:0]==0 and i_fwd_address[1:0]==0: o_fwd_hit=1, o_fwd_data=entry data.
  - First match of any other kind: o_fwd_stall=1.
  - No match: all forwarding outputs 0.
  - o_fwd_hit and o_fwd_stall are never both 1.
- Reset mid-WRITE: o_mem_write=0 on the next edge and all entries are lost.

Test Plan:
- Enqueue SW addr 0x100 data 0xDEADBEEF tag 3, commit tag 3, i_mem_ready after 2 cycles -> o_mem_write high with addr 0x100 / data 0xDEADBEEF / type 0 held until ready; one cycle later o_empty=1.
- Enqueue 4 stores tags 1..4 -> o_full=1, count=4; a 5th i_valid is ignored; commit 1..4 and drain -> writes in order 1..4 each after i_mem_ready, count returns to 0.
- Enqueue tags 5,6,7; commit 5; flush -> count=1, only tag 5 drains; a following enqueue of tag 8 lands at the correct wrapped tail.
- Commit tag 9 while oldest uncommitted is tag 6 -> o_commit_error pulses one cycle, no state change; then commit 6 succeeds.
- Forwarding: SW 0x200=0x11223344, then SB 0x201=0xAA:
  - lookup 0x200 -> o_fwd_stall=1.
  - With only the SW buffered, lookup 0x200 -> o_fwd_hit=1, data 0x11223344.
  - Lookup 0x204 -> no hit, no stall.
- Assert i_reset during WRITE with 3 entries -> next cycle o_mem_write=0, o_empty=1, count=0.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : store_buffer
// Description : In-order buffer of completed stores: commit tracking, drain
//               to the data cache, flush, and store-to-load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 6
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic [31:0]                i_address,
    input  logic [31:0]                i_data,
    input  logic [1:0]                 i_store_type,
    input  logic [TAG_WIDTH-1:0]       i_tag,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    input  logic                       i_commit,
    input  logic [TAG_WIDTH-1:0]       i_commit_tag,
    output logic                       o_commit_error,
    input  logic                       i_flush,
    output logic                       o_mem_write,
    output logic [31:0]                o_mem_address,
    output logic [31:0]                o_mem_data,
    output logic [1:0]                 o_mem_store_type,
    input  logic                       i_mem_ready,
    input  logic [31:0]                i_fwd_address,
    output logic                       o_fwd_hit,
    output logic [31:0]                o_fwd_data,
    output logic                       o_fwd_stall
);

    localparam int         c_PW        = $clog2(DEPTH);
    localparam int         c_CW        = $clog2(DEPTH) + 1;
    localparam logic [0:0] c_S_IDLE    = 1'b0;
    localparam logic [0:0] c_S_WRITE   = 1'b1;
    localparam logic [1:0] c_TYPE_WORD = 2'd0;
    localparam logic [1:0] c_TYPE_RSVD = 2'd3;

    logic [31:0]          r_addr [DEPTH];
    logic [31:0]          r_data [DEPTH];
    logic [1:0]           r_type [DEPTH];
    logic [TAG_WIDTH-1:0] r_tag  [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_committed;
    logic [c_PW-1:0]      r_head;
    logic [c_PW-1:0]      r_tail;
    logic [c_PW-1:0]      r_cpos;
    logic [c_CW-1:0]      r_count;
    logic [c_CW-1:0]      r_ccount;
    logic [0:0]           r_state;
    logic                 r_commit_error;

    logic                 w_full;
    logic                 w_enq;
    logic                 w_pop;
    logic                 w_commit_ok;
    logic [c_PW-1:0]      w_cpos_next;
    logic [c_CW-1:0]      w_ccount_next;
    logic [1:0]           w_type_norm;
    logic [c_PW-1:0]      w_fwd_idx;
    logic                 w_fwd_hit;
    logic                 w_fwd_stall;
    logic [31:0]          w_fwd_data;

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_enq   = i_valid && !w_full && !i_flush;
    assign w_pop   = (r_state == c_S_WRITE) && i_mem_ready;

    // An entry enqueued this cycle is not yet valid, so committing it fails here.
    assign w_commit_ok = i_commit && r_valid[r_cpos] && !r_committed[r_cpos]
                         && (r_tag[r_cpos] == i_commit_tag);

    assign w_cpos_next   = r_cpos + c_PW'(w_commit_ok);
    assign w_ccount_next = r_ccount + c_CW'(w_commit_ok) - c_CW'(w_pop);
    assign w_type_norm   = (i_store_type == c_TYPE_RSVD) ? c_TYPE_WORD : i_store_type;

    always_ff @(posedge i_clock) begin
        if (w_enq) begin
            r_addr[r_tail] <= i_address;
            r_data[r_tail] <= i_data;
            r_type[r_tail] <= w_type_norm;
            r_tag[r_tail]  <= i_tag;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid        <= '0;
            r_committed    <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_cpos         <= '0;
            r_count        <= '0;
            r_ccount       <= '0;
            r_state        <= c_S_IDLE;
            r_commit_error <= 1'b0;
        end else begin
            r_commit_error <= i_commit && !w_commit_ok;

            if (w_pop) begin
                r_valid[r_head]     <= 1'b0;
                r_committed[r_head] <= 1'b0;
                r_head              <= r_head + 1'b1;
            end

            if (w_commit_ok) begin
                r_committed[r_cpos] <= 1'b1;
            end
            r_cpos   <= w_cpos_next;
            r_ccount <= w_ccount_next;

            if (w_enq) begin
                r_valid[r_tail]     <= 1'b1;
                r_committed[r_tail] <= 1'b0;
            end

            // Flush keeps the committed prefix, including a commit landing this cycle.
            if (i_flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!r_committed[i] && !(w_commit_ok && (r_cpos == c_PW'(i)))) begin
                        r_valid[i] <= 1'b0;
                    end
                end
                r_tail  <= w_cpos_next;
                r_count <= w_ccount_next;
            end else begin
                r_tail  <= r_tail + c_PW'(w_enq);
                r_count <= r_count + c_CW'(w_enq) - c_CW'(w_pop);
            end

            case (r_state)
                c_S_IDLE: begin
                    if (r_valid[r_head] && r_committed[r_head]) begin
                        r_state <= c_S_WRITE;
                    end
                end
                c_S_WRITE: begin
                    if (i_mem_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_fwd_hit   = 1'b0;
        w_fwd_stall = 1'b0;
        w_fwd_data  = '0;
        w_fwd_idx   = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd_idx = r_head + c_PW'(i);
            if (r_valid[w_fwd_idx] && (r_addr[w_fwd_idx][31:2] == i_fwd_address[31:2])) begin
                if ((r_type[w_fwd_idx] == c_TYPE_WORD) && (r_addr[w_fwd_idx][1:0] == 2'b00)
                    && (i_fwd_address[1:0] == 2'b00)) begin
                    w_fwd_hit   = 1'b1;
                    w_fwd_stall = 1'b0;
                    w_fwd_data  = r_data[w_fwd_idx];
                end else begin
                    w_fwd_hit   = 1'b0;
                    w_fwd_stall = 1'b1;
                    w_fwd_data  = '0;
                end
            end
        end
    end

    assign o_full           = w_full;
    assign o_empty          = (r_count == '0);
    assign o_count          = r_count;
    assign o_commit_error   = r_commit_error;
    assign o_mem_write      = (r_state == c_S_WRITE);
    assign o_mem_address    = r_addr[r_head];
    assign o_mem_data       = r_data[r_head];
    assign o_mem_store_type = r_type[r_head];
    assign o_fwd_hit        = w_fwd_hit;
    assign o_fwd_stall      = w_fwd_stall;
    assign o_fwd_data       = w_fwd_data;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed scoreboard bench for store_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int TW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   data = '0;
    logic [1:0]    stype = '0;
    logic [TW-1:0] tag = '0;
    logic          commit = 1'b0;
    logic [TW-1:0] ctag = '0;
    logic          flush = 1'b0;
    logic          mem_ready = 1'b0;
    logic [31:0]   fwd_addr = '0;

    logic          o_full, o_empty, o_commit_error, o_mem_write;
    logic          o_fwd_hit, o_fwd_stall;
    logic [2:0]    o_count;
    logic [31:0]   o_mem_address, o_mem_data, o_fwd_data;
    logic [1:0]    o_mem_store_type;

    typedef struct packed {
        logic [31:0]   a;
        logic [31:0]   d;
        logic [1:0]    t;
        logic [TW-1:0] tag;
    } st_t;

    st_t pend[$];
    st_t expq[$];
    int  checks = 0;
    int  errors = 0;

    store_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_address(addr),
        .i_data(data), .i_store_type(stype), .i_tag(tag),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
        .i_commit(commit), .i_commit_tag(ctag), .o_commit_error(o_commit_error),
        .i_flush(flush), .o_mem_write(o_mem_write), .o_mem_address(o_mem_address),
        .o_mem_data(o_mem_data), .o_mem_store_type(o_mem_store_type),
        .i_mem_ready(mem_ready), .i_fwd_address(fwd_addr),
        .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data), .o_fwd_stall(o_fwd_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a write, compare with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && o_mem_write) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected actual_addr=%h expected=none", o_mem_address);
            end else begin
                check("mem_addr", o_mem_address, expq[0].a);
                check("mem_data", o_mem_data, expq[0].d);
                check("mem_type", {30'd0, o_mem_store_type}, {30'd0, expq[0].t});
                if (mem_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                       input logic [TW-1:0] tg);
        st_t e;
        valid = 1'b1; addr = a; data = d; stype = t; tag = tg;
        tick();
        valid = 1'b0;
        e.a = a; e.d = d; e.t = t; e.tag = tg;
        pend.push_back(e);
    endtask

    task automatic do_commit(input logic [TW-1:0] tg);
        logic exp_err;
        exp_err = 1'b1;
        if (pend.size() > 0 && pend[0].tag == tg) begin
            exp_err = 1'b0;
            expq.push_back(pend.pop_front());
        end
        commit = 1'b1; ctag = tg;
        tick();
        commit = 1'b0;
        check("commit_err", {31'd0, o_commit_error}, {31'd0, exp_err});
    endtask

    task automatic drain_one(input int hold);
        int n;
        n = 0;
        while (!o_mem_write && n < 20) begin
            tick();
            n++;
        end
        check("drain_start", {31'd0, o_mem_write}, 32'd1);
        if (o_mem_write) begin
            repeat (hold) tick();
            check("write_held", {31'd0, o_mem_write}, 32'd1);
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
    endtask

    task automatic fwd(input logic [31:0] a, input logic hit, input logic stall,
                       input logic [31:0] d);
        fwd_addr = a;
        #1;
        check("fwd_hit", {31'd0, o_fwd_hit}, {31'd0, hit});
        check("fwd_stall", {31'd0, o_fwd_stall}, {31'd0, stall});
        check("fwd_data", o_fwd_data, d);
        fwd_addr = '0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_empty", {31'd0, o_empty}, 32'd1);
        check("rst_full", {31'd0, o_full}, 32'd0);
        check("rst_count", {29'd0, o_count}, 32'd0);
        check("rst_mem_write", {31'd0, o_mem_write}, 32'd0);
        check("rst_commit_err", {31'd0, o_commit_error}, 32'd0);
        fwd(32'h0, 1'b0, 1'b0, 32'h0);

        // Single word store through commit and drain
        enq(32'h100, 32'hDEADBEEF, 2'd0, 6'd3);
        check("t1_count", {29'd0, o_count}, 32'd1);
        do_commit(6'd3);
        drain_one(2);
        check("t1_empty", {31'd0, o_empty}, 32'd1);
        check("t1_write_drop", {31'd0, o_mem_write}, 32'd0);

        // Fill, refuse overflow, commit and drain in order
        for (int i = 1; i <= 4; i++)
            enq(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd0, 6'(i));
        check("t2_full", {31'd0, o_full}, 32'd1);
        check("t2_count", {29'd0, o_count}, 32'd4);
        valid = 1'b1; addr = 32'h50; data = 32'hBAD0BAD0; stype = 2'd0; tag = 6'd5;
        tick();
        valid = 1'b0;
        check("t2_overflow_count", {29'd0, o_count}, 32'd4);
        for (int i = 1; i <= 4; i++) do_commit(6'(i));
        for (int i = 0; i < 4; i++) drain_one(1);
        check("t2_count_zero", {29'd0, o_count}, 32'd0);

        // Flush discards uncommitted tail; next enqueue lands at rewound tail
        enq(32'h20, 32'h5555_0005, 2'd0, 6'd5);
        enq(32'h24, 32'h5555_0006, 2'd0, 6'd6);
        enq(32'h28, 32'h5555_0007, 2'd0, 6'd7);
        do_commit(6'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pend.delete();
        check("t3_count", {29'd0, o_count}, 32'd1);
        fwd(32'h24, 1'b0, 1'b0, 32'h0);
        drain_one(0);
        enq(32'h40, 32'h8888_0008, 2'd0, 6'd8);
        do_commit(6'd8);
        fwd(32'h40, 1'b1, 1'b0, 32'h8888_0008);
        drain_one(1);

        // Wrong-tag commit pulses error without changing state
        enq(32'h30, 32'h6666_0006, 2'd0, 6'd6);
        do_commit(6'd9);
        check("t4_count", {29'd0, o_count}, 32'd1);
        check("t4_no_write", {31'd0, o_mem_write}, 32'd0);
        tick();
        check("t4_err_pulse", {31'd0, o_commit_error}, 32'd0);
        do_commit(6'd6);
        drain_one(1);

        // Commit in the same cycle as the enqueue is rejected
        valid = 1'b1; addr = 32'h60; data = 32'h1010_1010; stype = 2'd0; tag = 6'd10;
        commit = 1'b1; ctag = 6'd10;
        tick();
        valid = 1'b0; commit = 1'b0;
        check("t4_same_cycle_err", {31'd0, o_commit_error}, 32'd1);
        pend.push_back('{a: 32'h60, d: 32'h1010_1010, t: 2'd0, tag: 6'd10});
        do_commit(6'd10);
        drain_one(0);

        // Commit and flush together: the committed entry survives
        enq(32'h70, 32'h1313_1313, 2'd1, 6'd13);
        enq(32'h74, 32'h1414_1414, 2'd0, 6'd14);
        expq.push_back(pend.pop_front());
        commit = 1'b1; ctag = 6'd13; flush = 1'b1;
        tick();
        commit = 1'b0; flush = 1'b0;
        pend.delete();
        check("t4_flush_commit_cnt", {29'd0, o_count}, 32'd1);
        drain_one(1);

        // Forwarding
        enq(32'h200, 32'h11223344, 2'd0, 6'd11);
        fwd(32'h200, 1'b1, 1'b0, 32'h11223344);
        enq(32'h201, 32'h000000AA, 2'd2, 6'd12);
        fwd(32'h200, 1'b0, 1'b1, 32'h0);
        fwd(32'h204, 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pend.delete();
        check("t5_flush_empty", {31'd0, o_empty}, 32'd1);
        check("sb_drained", expq.size(), 32'd0);

        // Reset while a write is in progress
        enq(32'h300, 32'h2020_2020, 2'd0, 6'd20);
        enq(32'h304, 32'h2121_2121, 2'd0, 6'd21);
        enq(32'h308, 32'h2222_2222, 2'd0, 6'd22);
        do_commit(6'd20);
        begin
            int n;
            n = 0;
            while (!o_mem_write && n < 20) begin
                tick();
                n++;
            end
        end
        check("t6_in_write", {31'd0, o_mem_write}, 32'd1);
        rst = 1'b1;
        tick();
        check("t6_write_drop", {31'd0, o_mem_write}, 32'd0);
        check("t6_empty", {31'd0, o_empty}, 32'd1);
        check("t6_count", {29'd0, o_count}, 32'd0);
        rst = 1'b0;
        expq.delete();
        pend.delete();
        tick();
        check("t6_idle_after", {31'd0, o_mem_write}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
